// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush, bubble-masked control outputs and a saturating stall counter.
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int REG_AW = 4,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              prohib_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [BYTE_W-1:0] dob_byte_in,
  input  logic [REG_AW-1:0] rg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              prohib_out,
  output logic [DATA_W-1:0] result,
  output logic [BYTE_W-1:0] dob_byte,
  output logic [REG_AW-1:0] rg_mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  // state | meaning
  // EMPTY | no entry held, ready for input
  // ONE   | MAIN holds a beat driving the outputs, SKID empty
  // FULL  | MAIN and SKID both hold beats, input stalled
  // Encoding is {main_v, skid_v}, so the valid bits fall straight out of the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic main_v, skid_v;
  logic accept, drain;
  logic load_main_in, load_main_skid, load_skid;

  logic [CTRL_W-1:0] main_ctrl,   skid_ctrl;
  logic              main_prohib, skid_prohib;
  logic [DATA_W-1:0] main_result, skid_result;
  logic [BYTE_W-1:0] main_byte,   skid_byte;
  logic [REG_AW-1:0] main_rg,     skid_rg;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign main_v   = state[1];
  assign skid_v   = state[0];
  assign in_ready = !skid_v;
  assign accept   = in_valid & in_ready;
  assign drain    = main_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops everything, including a beat accepted in the same cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl   <= '0;
      main_prohib <= 1'b0;
      main_result <= '0;
      main_byte   <= '0;
      main_rg     <= '0;
      skid_ctrl   <= '0;
      skid_prohib <= 1'b0;
      skid_result <= '0;
      skid_byte   <= '0;
      skid_rg     <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl   <= ctrl_in;
        main_prohib <= prohib_in;
        main_result <= result_in;
        main_byte   <= dob_byte_in;
        main_rg     <= rg_in;
      end else if (load_main_skid) begin
        main_ctrl   <= skid_ctrl;
        main_prohib <= skid_prohib;
        main_result <= skid_result;
        main_byte   <= skid_byte;
        main_rg     <= skid_rg;
      end
      if (load_skid) begin
        skid_ctrl   <= ctrl_in;
        skid_prohib <= prohib_in;
        skid_result <= result_in;
        skid_byte   <= dob_byte_in;
        skid_rg     <= rg_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (main_v && !out_ready && !flush && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Control bits are masked on bubbles so a stale payload can never fire a write enable.
  assign out_valid  = main_v;
  assign ctrl_out   = main_v ? main_ctrl : '0;
  assign prohib_out = main_v & main_prohib;
  assign result     = main_result;
  assign dob_byte   = main_byte;
  assign rg_mem     = main_rg;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Scoreboard bench for exe_mem_pipe_reg: directed scenarios plus random traffic,
// checked against a 2-deep FIFO reference model with flush and a saturating stall count.
module tb_exe_mem_pipe_reg;

  typedef struct {
    logic [4:0]  ctrl;
    logic        prohib;
    logic [31:0] res;
    logic [7:0]  byt;
    logic [3:0]  rg;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [4:0]  ctrl_in;
  logic        prohib_in;
  logic [31:0] result_in;
  logic [7:0]  dob_byte_in;
  logic [3:0]  rg_in;

  logic        in_ready, out_valid, prohib_out;
  logic [4:0]  ctrl_out;
  logic [31:0] result;
  logic [7:0]  dob_byte;
  logic [3:0]  rg_mem;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2, prohib_out2;
  logic [4:0]  ctrl_out2;
  logic [31:0] result2;
  logic [7:0]  dob_byte2;
  logic [3:0]  rg_mem2;
  logic [1:0]  stall_cnt2;

  beat_t q[$];
  int    n_pass = 0;
  int    n_total = 0;
  bit    run = 1'b0;
  bit    snap_rdy = 1'b0;
  int    exp_stall = 0;
  int    exp_stall2 = 0;

  always #5 clk = ~clk;

  exe_mem_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .prohib_in(prohib_in), .result_in(result_in),
    .dob_byte_in(dob_byte_in), .rg_in(rg_in), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .prohib_out(prohib_out), .result(result), .dob_byte(dob_byte),
    .rg_mem(rg_mem), .stall_cnt(stall_cnt)
  );

  exe_mem_pipe_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .ctrl_in(ctrl_in), .prohib_in(prohib_in), .result_in(result_in),
    .dob_byte_in(dob_byte_in), .rg_in(rg_in), .out_valid(out_valid2), .out_ready(out_ready),
    .ctrl_out(ctrl_out2), .prohib_out(prohib_out2), .result(result2), .dob_byte(dob_byte2),
    .rg_mem(rg_mem2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic beat_t mk(input logic [4:0] c, input logic p, input logic [31:0] r,
                               input logic [7:0] b, input logic [3:0] g);
    beat_t t;
    t.ctrl = c; t.prohib = p; t.res = r; t.byt = b; t.rg = g;
    return t;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(5'($urandom), 1'($urandom), $urandom, 8'($urandom), 4'($urandom));
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drv(input logic iv, input logic ordy, input logic fl, input beat_t b);
    @(posedge clk);
    #1;
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    ctrl_in     = b.ctrl;
    prohib_in   = b.prohib;
    result_in   = b.res;
    dob_byte_in = b.byt;
    rg_in       = b.rg;
  endtask

  // Stimulus side of the scoreboard: record each beat the stage takes.
  always @(negedge clk) begin
    #1;
    if (rst_n && run && !flush && in_valid && snap_rdy)
      q.push_back(mk(ctrl_in, prohib_in, result_in, dob_byte_in, rg_in));
  end

  // Monitor: compare outputs against the FIFO head, then retire on handshake or flush.
  always @(negedge clk) begin
    if (rst_n && run) begin
      beat_t h;
      bit    ev;
      ev       = (q.size() > 0);
      snap_rdy = (q.size() < 2);
      h        = ev ? q[0] : mk(5'd0, 1'b0, 32'd0, 8'd0, 4'd0);
      chk("in_ready",    64'(in_ready),    64'(snap_rdy));
      chk("out_valid",   64'(out_valid),   64'(ev));
      chk("ctrl_out",    64'(ctrl_out),    64'(h.ctrl));
      chk("prohib_out",  64'(prohib_out),  64'(h.prohib));
      chk("stall_cnt",   64'(stall_cnt),   64'(exp_stall));
      chk("in_ready2",   64'(in_ready2),   64'(snap_rdy));
      chk("out_valid2",  64'(out_valid2),  64'(ev));
      chk("ctrl_out2",   64'(ctrl_out2),   64'(h.ctrl));
      chk("prohib_out2", 64'(prohib_out2), 64'(h.prohib));
      chk("stall_cnt2",  64'(stall_cnt2),  64'(exp_stall2));
      if (ev) begin
        chk("result",    64'(result),    64'(h.res));
        chk("dob_byte",  64'(dob_byte),  64'(h.byt));
        chk("rg_mem",    64'(rg_mem),    64'(h.rg));
        chk("result2",   64'(result2),   64'(h.res));
        chk("dob_byte2", 64'(dob_byte2), 64'(h.byt));
        chk("rg_mem2",   64'(rg_mem2),   64'(h.rg));
      end
      if (ev && !out_ready && !flush) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_stall2 < 3) exp_stall2++;
      end
      if (flush) q.delete();
      else if (ev && out_ready) void'(q.pop_front());
    end
  end

  initial begin
    beat_t idle;
    idle        = mk(5'd0, 1'b0, 32'd0, 8'd0, 4'd0);
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    ctrl_in     = '0;
    prohib_in   = 1'b0;
    result_in   = '0;
    dob_byte_in = '0;
    rg_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready",  64'(in_ready),  64'd1);
    chk("rst ctrl_out",  64'(ctrl_out),  64'd0);
    chk("rst result",    64'(result),    64'd0);
    chk("rst dob_byte",  64'(dob_byte),  64'd0);
    chk("rst rg_mem",    64'(rg_mem),    64'd0);
    chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    run   = 1'b1;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++)
      drv(1'b1, 1'b1, 1'b0, mk(5'b00011, 1'b0, 32'(i), 8'(i), 4'(i)));
    repeat (3) drv(1'b0, 1'b1, 1'b0, idle);

    // Back-pressure fills the skid entry, then drains in order.
    drv(1'b1, 1'b0, 1'b0, mk(5'b10000, 1'b0, 32'h11, 8'h11, 4'h1));
    drv(1'b1, 1'b0, 1'b0, mk(5'b00101, 1'b1, 32'h22, 8'h22, 4'h2));
    drv(1'b0, 1'b0, 1'b0, idle);
    repeat (4) drv(1'b0, 1'b1, 1'b0, idle);

    // Flush while FULL with an incoming beat.
    drv(1'b1, 1'b0, 1'b0, mk(5'b00001, 1'b0, 32'hA1, 8'hA1, 4'hA));
    drv(1'b1, 1'b0, 1'b0, mk(5'b00010, 1'b1, 32'hB2, 8'hB2, 4'hB));
    drv(1'b1, 1'b0, 1'b1, mk(5'b10001, 1'b1, 32'hC3, 8'hC3, 4'hC));
    repeat (3) drv(1'b0, 1'b1, 1'b0, idle);

    // Asynchronous reset mid-cycle while FULL.
    drv(1'b1, 1'b0, 1'b0, mk(5'b11111, 1'b1, 32'hD4, 8'hD4, 4'hD));
    drv(1'b1, 1'b0, 1'b0, mk(5'b11111, 1'b1, 32'hE5, 8'hE5, 4'hE));
    drv(1'b0, 1'b0, 1'b0, idle);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid",  64'(out_valid),  64'd0);
    chk("arst in_ready",   64'(in_ready),   64'd1);
    chk("arst ctrl_out",   64'(ctrl_out),   64'd0);
    chk("arst prohib_out", 64'(prohib_out), 64'd0);
    chk("arst result",     64'(result),     64'd0);
    chk("arst dob_byte",   64'(dob_byte),   64'd0);
    chk("arst rg_mem",     64'(rg_mem),     64'd0);
    chk("arst stall_cnt",  64'(stall_cnt),  64'd0);
    chk("arst stall_cnt2", 64'(stall_cnt2), 64'd0);
    q.delete();
    exp_stall  = 0;
    exp_stall2 = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Long stall: the 2-bit counter must saturate at 3.
    drv(1'b1, 1'b0, 1'b0, mk(5'b01010, 1'b0, 32'h55, 8'h55, 4'h5));
    repeat (6) drv(1'b0, 1'b0, 1'b0, idle);
    repeat (2) drv(1'b0, 1'b1, 1'b0, idle);

    // Random traffic.
    for (int i = 0; i < 10000; i++)
      drv(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 19) == 0), rnd_beat());
    repeat (5) drv(1'b0, 1'b1, 1'b0, idle);
    @(negedge clk);
    #2;
    chk("final queue empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
